mantissa_multiplier: RTL

- Sequential shift-add multiplier for floating-point mantissas. It is the multiply counterpart of the team's mantissa divider in the FP datapath.
- Takes two WIDTH-bit fraction fields with implicit leading 1, computes {1,m1}*{1,m2} over WIDTH+1 cycles, normalizes, and returns a WIDTH-bit truncated fraction plus an exponent-increment flag.
- Sits between operand unpack and exponent adjust/pack. Uses a valid/ready handshake on both sides.

---
 rtl/mantissa_multiplier_if.sv | 24 ++
 rtl/mantissa_multiplier.sv | 83 ++++++++
 2 files changed

// File: rtl/mantissa_multiplier_if.sv
// Operand/result handshake bundle for the mantissa multiplier.
// The master side issues operands and accepts results; the slave side is the multiplier.
interface mantissa_multiplier_if #(
    parameter int unsigned WIDTH = 24
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] m1;
    logic [WIDTH-1:0] m2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] m3;
    logic             increment_exponent;

    modport master (
        output in_valid, m1, m2, out_ready,
        input  in_ready, out_valid, m3, increment_exponent
    );

    modport slave (
        input  in_valid, m1, m2, out_ready,
        output in_ready, out_valid, m3, increment_exponent
    );
endinterface

// File: rtl/mantissa_multiplier.sv
// Sequential shift-add multiplier for floating-point mantissas.
// Multiplies {1,m1} by {1,m2} over WIDTH+1 cycles, then returns the truncated, normalized
// fraction and a flag telling the exponent stage to add one.
module mantissa_multiplier #(
    parameter int unsigned WIDTH = 24
) (
    input logic                  clk,
    input logic                  rst_n,
    mantissa_multiplier_if.slave bus
);
    localparam int unsigned PW = 2 * WIDTH + 2;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_t;

    state_t           state_q;
    logic [WIDTH:0]   a_q;
    logic [WIDTH:0]   b_q;
    logic [PW-1:0]    p_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] m3_q;
    logic             inc_q;

    logic [PW-1:0]    addend;
    logic [PW-1:0]    p_acc;
    logic             norm_inc;
    logic [WIDTH-1:0] norm_frac;

    // Partial product for the current multiplier bit, plus normalization of the running sum.
    // The implicit leading ones guarantee the product's top set bit is at 2W or 2W+1.
    always_comb begin
        addend    = PW'(a_q) << count_q;
        p_acc     = b_q[0] ? (p_q + addend) : p_q;
        norm_inc  = p_acc[PW-1];
        norm_frac = norm_inc ? p_acc[2*WIDTH -: WIDTH] : p_acc[2*WIDTH-1 -: WIDTH];
    end

    assign bus.in_ready           = (state_q == StIdle);
    assign bus.out_valid          = (state_q == StDone);
    assign bus.m3                 = m3_q;
    assign bus.increment_exponent = inc_q;

    // Control FSM and datapath; results are captured only on the final BUSY edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            count_q <= '0;
            m3_q    <= '0;
            inc_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        a_q     <= {1'b1, bus.m1};
                        b_q     <= {1'b1, bus.m2};
                        p_q     <= '0;
                        count_q <= '0;
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    p_q     <= p_acc;
                    b_q     <= b_q >> 1;
                    count_q <= count_q + CW'(1);
                    if (count_q == CW'(WIDTH)) begin
                        m3_q    <= norm_frac;
                        inc_q   <= norm_inc;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule
